// File: rtl/xif_mac_pkg.sv
// rtl/xif_mac_pkg.sv - shared constants and types for the X-interface MAC coprocessor
// Purpose: opcode/funct constants, interface widths, funct3 and FSM enums, and
// the struct that holds an accepted instruction while it waits for commit.
// Ports: none (package).
package xif_mac_pkg;

  localparam int          X_ID_WIDTH  = 4;
  localparam int          X_RFR_WIDTH = 32;
  localparam logic [6:0]  MAC_OPCODE  = 7'b0001011;
  localparam logic [6:0]  MAC_FUNCT7  = 7'b0000000;

  typedef enum logic [2:0] {
    F3_MAC   = 3'b000,
    F3_CLR   = 3'b001,
    F3_RDACC = 3'b010
  } funct3_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT_COMMIT,
    ST_EXEC,
    ST_RESULT
  } state_e;

  typedef struct packed {
    logic [X_ID_WIDTH-1:0]  id;
    funct3_e                funct3;
    logic [4:0]             rd;
    logic [X_RFR_WIDTH-1:0] rs1;
    logic [X_RFR_WIDTH-1:0] rs2;
  } instr_t;

endpackage

// File: rtl/if_xif.sv
// rtl/if_xif.sv - eXtension interface bundle shared between CPU and coprocessor
// Purpose: groups the compressed, issue, commit, mem, mem_result and result
// channels; each coproc_* modport gives the coprocessor view of one channel.
// Ports: none (signals listed below, direction set by modport).
interface if_xif #(
  parameter int X_ID_WIDTH  = xif_mac_pkg::X_ID_WIDTH,
  parameter int X_RFR_WIDTH = xif_mac_pkg::X_RFR_WIDTH
);

  logic                         compressed_valid;
  logic                         compressed_ready;
  logic [15:0]                  compressed_req;
  logic [32:0]                  compressed_resp;

  logic                         issue_valid;
  logic                         issue_ready;
  logic [31:0]                  issue_req_instr;
  logic [X_ID_WIDTH-1:0]        issue_req_id;
  logic [1:0][X_RFR_WIDTH-1:0]  issue_req_rs;
  logic [1:0]                   issue_req_rs_valid;
  logic                         issue_resp_accept;
  logic                         issue_resp_writeback;
  logic [1:0]                   issue_resp_register_read;

  logic                         commit_valid;
  logic [X_ID_WIDTH-1:0]        commit_id;
  logic                         commit_kill;

  logic                         mem_valid;
  logic                         mem_ready;
  logic [63:0]                  mem_req;
  logic [1:0]                   mem_resp;

  logic                         mem_result_valid;
  logic [31:0]                  mem_result;

  logic                         result_valid;
  logic                         result_ready;
  logic [X_ID_WIDTH-1:0]        result_id;
  logic [31:0]                  result_data;
  logic [4:0]                   result_rd;
  logic                         result_we;

  modport coproc_compressed (
    input  compressed_valid, compressed_req,
    output compressed_ready, compressed_resp
  );

  modport coproc_issue (
    input  issue_valid, issue_req_instr, issue_req_id, issue_req_rs, issue_req_rs_valid,
    output issue_ready, issue_resp_accept, issue_resp_writeback, issue_resp_register_read
  );

  modport coproc_commit (
    input  commit_valid, commit_id, commit_kill
  );

  modport coproc_mem (
    input  mem_ready, mem_resp,
    output mem_valid, mem_req
  );

  modport coproc_mem_result (
    input  mem_result_valid, mem_result
  );

  modport coproc_result (
    input  result_ready,
    output result_valid, result_id, result_data, result_rd, result_we
  );

endinterface

// File: rtl/xif_mac_decoder.sv
// rtl/xif_mac_decoder.sv - combinational decode of the custom MAC/CLR/RDACC encodings
// Purpose: classifies an offered instruction and produces the issue response.
// Ports:
//   opcode_i, funct3_i, funct7_i  instruction fields of the offered instruction
//   rs_valid_i                    operand-valid flags from the CPU
//   accept_o                      legal encoding with all needed operands present
//   writeback_o                   accepted instruction that writes rd (MAC, RDACC)
//   register_read_o               source operands consumed by the accepted instruction
module xif_mac_decoder
  import xif_mac_pkg::*;
(
  input  logic [6:0] opcode_i,
  input  logic [2:0] funct3_i,
  input  logic [6:0] funct7_i,
  input  logic [1:0] rs_valid_i,
  output logic       accept_o,
  output logic       writeback_o,
  output logic [1:0] register_read_o
);

  logic is_mac;
  logic is_clr;
  logic is_rdacc;

  always_comb begin
    is_mac   = 1'b0;
    is_clr   = 1'b0;
    is_rdacc = 1'b0;
    if (opcode_i == MAC_OPCODE && funct7_i == MAC_FUNCT7) begin
      case (funct3_i)
        F3_MAC:   is_mac   = 1'b1;
        F3_CLR:   is_clr   = 1'b1;
        F3_RDACC: is_rdacc = 1'b1;
        default:  ;
      endcase
    end
  end

  // MAC needs both operands; CLR and RDACC ignore the register file entirely.
  assign accept_o        = (is_mac && (&rs_valid_i)) || is_clr || is_rdacc;
  assign writeback_o     = accept_o && (is_mac || is_rdacc);
  assign register_read_o = (accept_o && is_mac) ? 2'b11 : 2'b00;

endmodule

// File: rtl/xif_mac_coproc.sv
// rtl/xif_mac_coproc.sv - single-issue multiply-accumulate coprocessor on the X-interface
// Purpose: accepts MAC/CLR/RDACC, waits for commit, executes in one cycle and
// returns one result per committed instruction.
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   xif_compressed_if    unused, tied off
//   xif_issue_if         issue handshake and combinational issue response
//   xif_commit_if        commit / kill of the outstanding instruction
//   xif_mem_if           unused, tied off
//   xif_mem_result_if    unused, ignored
//   xif_result_if        result channel (id, rd, we, data)
//   busy_o               high whenever the FSM is not idle
module xif_mac_coproc
  import xif_mac_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  if_xif.coproc_compressed xif_compressed_if,
  if_xif.coproc_issue      xif_issue_if,
  if_xif.coproc_commit     xif_commit_if,
  if_xif.coproc_mem        xif_mem_if,
  if_xif.coproc_mem_result xif_mem_result_if,
  if_xif.coproc_result     xif_result_if,
  output logic             busy_o
);

  state_e      state_q, state_d;
  instr_t      instr_q, instr_d;
  logic [31:0] acc_q, acc_d;
  logic [31:0] res_data_q, res_data_d;

  logic        dec_accept;
  logic        dec_writeback;
  logic [1:0]  dec_register_read;
  logic        issue_fire;
  logic        commit_on_issue;
  logic        commit_on_held;
  logic [31:0] product;
  logic [31:0] mac_sum;

  xif_mac_decoder u_decoder (
    .opcode_i        (xif_issue_if.issue_req_instr[6:0]),
    .funct3_i        (xif_issue_if.issue_req_instr[14:12]),
    .funct7_i        (xif_issue_if.issue_req_instr[31:25]),
    .rs_valid_i      (xif_issue_if.issue_req_rs_valid),
    .accept_o        (dec_accept),
    .writeback_o     (dec_writeback),
    .register_read_o (dec_register_read)
  );

  assign issue_fire      = xif_issue_if.issue_valid && (state_q == ST_IDLE) && dec_accept;
  // The CPU may commit in the very cycle it hands the instruction over.
  assign commit_on_issue = xif_commit_if.commit_valid &&
                           (xif_commit_if.commit_id == xif_issue_if.issue_req_id);
  assign commit_on_held  = xif_commit_if.commit_valid &&
                           (xif_commit_if.commit_id == instr_q.id);
  // Only the low 32 bits of the product matter; the accumulator wraps.
  assign product         = instr_q.rs1 * instr_q.rs2;
  assign mac_sum         = acc_q + product;

  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    acc_d      = acc_q;
    res_data_d = res_data_q;
    case (state_q)
      ST_IDLE: begin
        if (issue_fire) begin
          instr_d.id     = xif_issue_if.issue_req_id;
          instr_d.funct3 = funct3_e'(xif_issue_if.issue_req_instr[14:12]);
          instr_d.rd     = xif_issue_if.issue_req_instr[11:7];
          instr_d.rs1    = xif_issue_if.issue_req_rs[0];
          instr_d.rs2    = xif_issue_if.issue_req_rs[1];
          if (commit_on_issue) begin
            state_d = xif_commit_if.commit_kill ? ST_IDLE : ST_EXEC;
          end else begin
            state_d = ST_WAIT_COMMIT;
          end
        end
      end
      ST_WAIT_COMMIT: begin
        if (commit_on_held) begin
          state_d = xif_commit_if.commit_kill ? ST_IDLE : ST_EXEC;
        end
      end
      ST_EXEC: begin
        case (instr_q.funct3)
          F3_MAC: begin
            acc_d      = mac_sum;
            res_data_d = mac_sum;
          end
          F3_CLR: begin
            acc_d      = '0;
            res_data_d = '0;
          end
          F3_RDACC: res_data_d = acc_q;
          default:  res_data_d = '0;
        endcase
        state_d = ST_RESULT;
      end
      ST_RESULT: begin
        if (xif_result_if.result_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q    <= ST_IDLE;
      instr_q    <= '0;
      acc_q      <= '0;
      res_data_q <= '0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      acc_q      <= acc_d;
      res_data_q <= res_data_d;
    end
  end

  assign xif_issue_if.issue_ready              = (state_q == ST_IDLE);
  assign xif_issue_if.issue_resp_accept        = dec_accept;
  assign xif_issue_if.issue_resp_writeback     = dec_writeback;
  assign xif_issue_if.issue_resp_register_read = dec_register_read;

  // All result fields come straight from registers, so they hold while stalled.
  assign xif_result_if.result_valid = (state_q == ST_RESULT);
  assign xif_result_if.result_id    = instr_q.id;
  assign xif_result_if.result_rd    = instr_q.rd;
  assign xif_result_if.result_we    = (instr_q.funct3 != F3_CLR);
  assign xif_result_if.result_data  = res_data_q;

  assign xif_compressed_if.compressed_ready = 1'b0;
  assign xif_compressed_if.compressed_resp  = '0;
  assign xif_mem_if.mem_valid               = 1'b0;
  assign xif_mem_if.mem_req                 = '0;

  assign busy_o = (state_q != ST_IDLE);

  logic unused_xif;
  assign unused_xif = ^{xif_compressed_if.compressed_valid, xif_compressed_if.compressed_req,
                        xif_mem_if.mem_ready, xif_mem_if.mem_resp,
                        xif_mem_result_if.mem_result_valid, xif_mem_result_if.mem_result,
                        xif_issue_if.issue_req_instr[24:15]};

endmodule
